// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM of the multicycle RV32 core: sequences fetch/decode/execute/
// memory/writeback, drives datapath selects and supervises the memory handshake.
module riscv_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       irWrite,
    output logic       memRead,
    output logic       memWrite,
    output logic       iorD,
    output logic       regWrite,
    output logic [1:0] aluOp,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] resultSrc,
    output logic       illegal,
    output logic       busError,
    output logic [3:0] state
);

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_HALT   = 4'd15
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             bus_error_q;
    logic             set_error;
    logic             timeout_hit;
    logic             in_mem_state;

    // A memory state has run out its budget only if memReady did not rescue it this cycle.
    assign timeout_hit  = (MEM_TIMEOUT != 0) && (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) && !memReady;
    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Wait counter restarts on every state change, so each memory state begins at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else if (state_d != state_q) begin
            wait_cnt_q <= '0;
        end else if (in_mem_state && !memReady && (wait_cnt_q != {CNT_W{1'b1}})) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_error_q <= 1'b0;
        end else if (set_error) begin
            bus_error_q <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        pcWrite   = 1'b0;
        irWrite   = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        iorD      = 1'b0;
        regWrite  = 1'b0;
        aluOp     = 2'b00;
        aluSrcA   = 2'b00;
        aluSrcB   = 2'b00;
        resultSrc = 2'b00;
        illegal   = 1'b0;
        set_error = 1'b0;

        case (state_q)
            S_FETCH: begin
                memRead   = 1'b1;
                aluSrcB   = 2'b01;
                resultSrc = 2'b10;
                pcWrite   = memReady;
                irWrite   = memReady;
                if (memReady) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    set_error = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b10;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_BRANCH:    state_d = S_BRANCH;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b10;
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                if (memReady) begin
                    state_d = S_MEMWB;
                end else if (timeout_hit) begin
                    set_error = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_MEMWB: begin
                regWrite  = 1'b1;
                resultSrc = 2'b01;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
                if (memReady) begin
                    state_d = S_FETCH;
                end else if (timeout_hit) begin
                    set_error = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXEC_R: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b00;
                aluOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXEC_I: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b00;
                aluOp   = 2'b01;
                case (funct3)
                    F3_BEQ:  pcWrite = zero;
                    F3_BNE:  pcWrite = !zero;
                    default: illegal = 1'b1;
                endcase
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset dominates every enable, even the memReady-driven ones.
        if (reset) begin
            pcWrite  = 1'b0;
            irWrite  = 1'b0;
            memRead  = 1'b0;
            memWrite = 1'b0;
            regWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign busError = bus_error_q;
    assign state    = 4'(state_q);

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl: state sequences, control outputs,
// branch resolution, illegal opcodes, memory timeout and reset behaviour.
module tb_riscv_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       memReady;
    logic       pcWrite;
    logic       irWrite;
    logic       memRead;
    logic       memWrite;
    logic       iorD;
    logic       regWrite;
    logic [1:0] aluOp;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] resultSrc;
    logic       illegal;
    logic       busError;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    riscv_multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .funct3   (funct3),
        .zero     (zero),
        .memReady (memReady),
        .pcWrite  (pcWrite),
        .irWrite  (irWrite),
        .memRead  (memRead),
        .memWrite (memWrite),
        .iorD     (iorD),
        .regWrite (regWrite),
        .aluOp    (aluOp),
        .aluSrcA  (aluSrcA),
        .aluSrcB  (aluSrcB),
        .resultSrc(resultSrc),
        .illegal  (illegal),
        .busError (busError),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset    = 1'b1;
        memReady = 1'b1;
        opcode   = 7'b0110011;
        funct3   = 3'b000;
        zero     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++;
        if ({pcWrite, irWrite, memRead, memWrite, regWrite, illegal} !== 6'b0) begin
            errors++;
            $display("FAIL reset_enables got %b exp 000000", {pcWrite, irWrite, memRead, memWrite, regWrite, illegal});
        end
        checks++;
        if (busError !== 1'b0) begin errors++; $display("FAIL reset_buserror got %b exp 0", busError); end
        reset = 1'b0;
    endtask

    task automatic test_rtype();
        int exp_st[5] = '{0, 1, 6, 8, 0};
        opcode   = 7'b0110011;
        memReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state !== 4'(exp_st[i])) begin errors++; $display("FAIL rtype_state[%0d] got %0d exp %0d", i, state, exp_st[i]); end
            checks++;
            if (regWrite !== 1'(exp_st[i] == 8)) begin errors++; $display("FAIL rtype_regwrite[%0d] got %b exp %b", i, regWrite, exp_st[i] == 8); end
            checks++;
            if ({pcWrite, irWrite} !== {2{1'(exp_st[i] == 0)}}) begin
                errors++;
                $display("FAIL rtype_pc_ir[%0d] got %b%b exp %b", i, pcWrite, irWrite, exp_st[i] == 0);
            end
            if (exp_st[i] == 6) begin
                checks++;
                if ({aluOp, aluSrcA, aluSrcB} !== 6'b10_10_00) begin
                    errors++;
                    $display("FAIL rtype_exec_ctrl got %b exp 101000", {aluOp, aluSrcA, aluSrcB});
                end
            end
            if (i < 4) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_itype();
        int exp_st[5] = '{0, 1, 7, 8, 0};
        opcode   = 7'b0010011;
        memReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state !== 4'(exp_st[i])) begin errors++; $display("FAIL itype_state[%0d] got %0d exp %0d", i, state, exp_st[i]); end
            if (exp_st[i] == 7) begin
                checks++;
                if ({aluOp, aluSrcA, aluSrcB} !== 6'b00_10_10) begin
                    errors++;
                    $display("FAIL itype_exec_ctrl got %b exp 001010", {aluOp, aluSrcA, aluSrcB});
                end
            end
            if (i < 4) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_load_wait();
        int   exp_st[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
        logic rdy[9]    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        opcode = 7'b0000011;
        for (int i = 0; i < 9; i++) begin
            memReady = rdy[i];
            #1;
            checks++;
            if (state !== 4'(exp_st[i])) begin errors++; $display("FAIL lw_state[%0d] got %0d exp %0d", i, state, exp_st[i]); end
            checks++;
            if (memWrite !== 1'b0) begin errors++; $display("FAIL lw_memwrite[%0d] got %b exp 0", i, memWrite); end
            if (exp_st[i] == 3) begin
                checks++;
                if ({memRead, iorD, regWrite} !== 3'b110) begin
                    errors++;
                    $display("FAIL lw_memrd_ctrl[%0d] got %b exp 110", i, {memRead, iorD, regWrite});
                end
            end
            if (exp_st[i] == 4) begin
                checks++;
                if ({regWrite, resultSrc, memRead} !== 4'b1_01_0) begin
                    errors++;
                    $display("FAIL lw_memwb_ctrl got %b exp 1010", {regWrite, resultSrc, memRead});
                end
            end
            if (i < 8) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3[5]     = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010};
        logic       zf[5]     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       exp_pc[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_il[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        opcode   = 7'b1100011;
        memReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            funct3 = f3[k];
            zero   = zf[k];
            // FETCH and DECODE
            repeat (2) begin @(posedge clk); #1; end
            #1;
            checks++;
            if (state !== 4'd9) begin errors++; $display("FAIL br_state[%0d] got %0d exp 9", k, state); end
            checks++;
            if (pcWrite !== exp_pc[k]) begin errors++; $display("FAIL br_pcwrite[%0d] got %b exp %b", k, pcWrite, exp_pc[k]); end
            checks++;
            if (illegal !== exp_il[k]) begin errors++; $display("FAIL br_illegal[%0d] got %b exp %b", k, illegal, exp_il[k]); end
            checks++;
            if ({aluOp, aluSrcA, aluSrcB} !== 6'b01_10_00) begin
                errors++;
                $display("FAIL br_alu_ctrl[%0d] got %b exp 011000", k, {aluOp, aluSrcA, aluSrcB});
            end
            @(posedge clk); #1;
            checks++;
            if (state !== 4'd0) begin errors++; $display("FAIL br_return[%0d] got %0d exp 0", k, state); end
        end
        zero   = 1'b0;
        funct3 = 3'b000;
    endtask

    task automatic test_illegal();
        int exp_st[3] = '{0, 1, 0};
        opcode   = 7'b1111111;
        memReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (state !== 4'(exp_st[i])) begin errors++; $display("FAIL ill_state[%0d] got %0d exp %0d", i, state, exp_st[i]); end
            checks++;
            if (illegal !== 1'(exp_st[i] == 1)) begin errors++; $display("FAIL ill_pulse[%0d] got %b exp %b", i, illegal, exp_st[i] == 1); end
            checks++;
            if ({regWrite, memWrite} !== 2'b00) begin errors++; $display("FAIL ill_writes[%0d] got %b exp 00", i, {regWrite, memWrite}); end
            if (i < 2) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_timeout();
        memReady = 1'b0;
        opcode   = 7'b0110011;
        // Counter values 0..15 are seen in FETCH; the 15 limit with no ready halts.
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if ({state, busError, memRead, pcWrite} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL to_wait[%0d] got st=%0d be=%b rd=%b pc=%b exp st=0 be=0 rd=1 pc=0", i, state, busError, memRead, pcWrite);
            end
            @(posedge clk); #1;
        end
        memReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (state !== 4'd15) begin errors++; $display("FAIL to_halt_state[%0d] got %0d exp 15", i, state); end
            checks++;
            if (busError !== 1'b1) begin errors++; $display("FAIL to_buserror[%0d] got %b exp 1", i, busError); end
            checks++;
            if ({pcWrite, irWrite, memRead, memWrite, regWrite, illegal} !== 6'b0) begin
                errors++;
                $display("FAIL to_halt_enables[%0d] got %b exp 000000", i, {pcWrite, irWrite, memRead, memWrite, regWrite, illegal});
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({state, busError} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL to_recover got st=%0d be=%b exp st=0 be=0", state, busError);
        end
    endtask

    task automatic test_ready_at_limit();
        int exp_st[4] = '{1, 6, 8, 0};
        memReady = 1'b0;
        opcode   = 7'b0110011;
        for (int i = 0; i < 15; i++) begin @(posedge clk); #1; end
        memReady = 1'b1;
        #1;
        checks++;
        if ({state, pcWrite} !== {4'd0, 1'b1}) begin
            errors++;
            $display("FAIL lim_fetch got st=%0d pc=%b exp st=0 pc=1", state, pcWrite);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({state, busError} !== {4'(exp_st[i]), 1'b0}) begin
                errors++;
                $display("FAIL lim_seq[%0d] got st=%0d be=%b exp st=%0d be=0", i, state, busError, exp_st[i]);
            end
        end
    endtask

    task automatic test_reset_in_memwr();
        int exp_st[4] = '{0, 1, 2, 5};
        opcode = 7'b0100011;
        for (int i = 0; i < 4; i++) begin
            memReady = (i < 3);
            #1;
            checks++;
            if (state !== 4'(exp_st[i])) begin errors++; $display("FAIL sw_state[%0d] got %0d exp %0d", i, state, exp_st[i]); end
            if (i < 3) begin @(posedge clk); #1; end
        end
        checks++;
        if ({memWrite, iorD} !== 2'b11) begin errors++; $display("FAIL sw_memwr_ctrl got %b exp 11", {memWrite, iorD}); end
        reset = 1'b1;
        #1;
        checks++;
        if (memWrite !== 1'b0) begin errors++; $display("FAIL sw_reset_gate got %b exp 0", memWrite); end
        @(posedge clk); #1;
        checks++;
        if ({state, memWrite} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL sw_after_reset got st=%0d wr=%b exp st=0 wr=0", state, memWrite);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        opcode   = '0;
        funct3   = '0;
        zero     = 1'b0;
        memReady = 1'b0;
        test_reset();
        test_rtype();
        test_itype();
        test_load_wait();
        test_branch();
        test_illegal();
        test_timeout();
        test_ready_at_limit();
        test_reset_in_memwr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
Main control FSM for the multicycle RV32 core. It sequences the shared ALU, register file, memory port, PC and IR across fetch/decode/execute/memory/writeback steps. It drives the 2-bit aluOp consumed by the ALU control decoder (00 add, 01 sub, 10 funct-decoded). It also supervises the memory handshake, with a timeout that halts the core on a bus error.

Parameters:
MEM_TIMEOUT, 15, max cycles to wait for memReady in any memory state; 0 disables the timeout.
CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]; used only for branch type
zero  in  1  ALU zero flag
memReady  in  1  memory completes current read/write this cycle
pcWrite  out  1  load PC
irWrite  out  1  load IR (and oldPC)
memRead  out  1  memory read request
memWrite  out  1  memory write request
iorD  out  1  0 = address from PC, 1 = address from ALUOut
regWrite  out  1  register file write
aluOp  out  2  to ALU control decoder
aluSrcA  out  2  00 PC, 01 oldPC, 10 regA
aluSrcB  out  2  00 regB, 01 const 4, 10 immediate
resultSrc  out  2  00 ALUOut, 01 memData, 10 ALU result
illegal  out  1  one-cycle pulse when an opcode or branch funct3 is unsupported
busError  out  1  sticky; set on memory timeout
state  out  4  current state, for debug and the bench

Behaviour:
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, HALT=15.
- Reset: on a clk edge with reset=1, the FSM goes to FETCH, the wait counter clears and busError clears.
  - While reset is high, every enable output is 0: pcWrite, irWrite, memRead, memWrite, regWrite, illegal.
  - Reset mid-instruction abandons the instruction; nothing is written afterwards.
- Outputs are decoded from state (Moore), except pcWrite in FETCH/BRANCH and irWrite (see below). Any output not listed for a state is 0.
- FETCH:
  - memRead=1, iorD=0, aluSrcA=00, aluSrcB=01, aluOp=00, resultSrc=10.
  - pcWrite=irWrite=memReady.
  - memReady=1: go to DECODE. Otherwise stay.
- DECODE:
  - aluSrcA=01, aluSrcB=10, aluOp=00 (branch target into ALUOut).
  - Next state by opcode:
    - 0000011 (lw) or 0100011 (sw): MEMADR.
    - 0110011: EXEC_R.
    - 0010011: EXEC_I.
    - 1100011: BRANCH.
    - Any other opcode: pulse illegal and go to FETCH.
- MEMADR:
  - aluSrcA=10, aluSrcB=10, aluOp=00.
  - Next: MEMRD for lw, MEMWR for sw.
- MEMRD: memRead=1, iorD=1. memReady=1: go to MEMWB; otherwise stay.
- MEMWB: regWrite=1, resultSrc=01. Next: FETCH.
- MEMWR: memWrite=1, iorD=1. memReady=1: go to FETCH; otherwise stay.
- EXEC_R: aluSrcA=10, aluSrcB=00, aluOp=10. Next: ALUWB.
- EXEC_I: aluSrcA=10, aluSrcB=10, aluOp=00. Next: ALUWB.
- ALUWB: regWrite=1, resultSrc=00. Next: FETCH.
- BRANCH:
  - aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00.
  - pcWrite = (funct3==000 & zero) | (funct3==001 & ~zero).
  - funct3 not in {000, 001}: pcWrite=0 and illegal pulses.
  - Next: FETCH.
- Wait counter:
  - Clears on entry to each memory state (FETCH, MEMRD, MEMWR).
  - Increments each cycle the FSM stays there with memReady=0.
  - If MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT with memReady still 0: set busError and go to HALT.
  - memReady in the same cycle as the limit takes priority: the transfer completes and there is no error.
- HALT: all enables 0; remains until reset.
- Cycle counts with zero memory wait:
  - R-type / I-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - branch: 3 cycles.
  - Each memory wait cycle adds 1.

Test Plan:
- Reset held 2 cycles, then released with memReady=1 and opcode=0110011 → state sequence 0,1,6,8,0. aluOp=10 in EXEC_R. regWrite=1 only in ALUWB. pcWrite=irWrite=1 only in FETCH.
- lw (0000011), memReady low for 3 cycles in MEMRD → sequence 0,1,2,3,3,3,3,4,0. iorD=1 in MEMRD. resultSrc=01 with regWrite=1 in MEMWB.
- beq (funct3=000) run twice, zero=1 then zero=0 → pcWrite=1 in BRANCH for the first run, 0 for the second. aluOp=01 in both. bne (001) gives the inverse result.
- opcode 1111111 → illegal pulses for exactly 1 cycle in DECODE. Next state FETCH. No regWrite or memWrite at any point.
- MEM_TIMEOUT=15, memReady held 0 in FETCH → after 15 wait cycles busError=1 and state=15, with all enables 0. Reset returns state to 0 and clears busError. Separately, memReady=1 on the limit cycle → no error.
- reset asserted during MEMWR with memReady=0 → memWrite=0 from that edge onward and state=0.
